mode_btn_ctrl: RTL and testbench
================================

// Module: mode_btn_ctrl
// PURPOSE
//  Conditions the raw mode push-button and feeds the watch top level, upstream of its mode input.
//  - Synchronises and debounces the button.
//  - Classifies each press as short or long.
//  - Short press: toggles o_mode (0 = clock view, 1 = up-counter view).
//  - Long press: emits a one-cycle clear pulse for the counters.
// PARAMETERS
//  DEBOUNCE_CYC  1_000_000    consecutive stable samples to accept an edge (10 ms at 100 MHz); >=2
//  LONG_CYC      100_000_000  debounced-held cycles for a long press (1 s); >DEBOUNCE_CYC
//  BTN_ACT_HIGH  1            1: pressed = i_btn high; 0: pressed = i_btn low
// PORTS
//  sysclk         in   1  system clock, all logic on rising edge
//  i_rst_n        in   1  asynchronous active-low reset
//  i_btn          in   1  raw asynchronous button pin
//  o_mode         out  1  display mode select, toggles on each short press
//  o_short_pulse  out  1  one-cycle pulse, short press completed
//  o_long_pulse   out  1  one-cycle pulse, long-press threshold reached
//  o_pressed      out  1  debounced button level (1 while in HELD/LONG)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, counters=0, sync FFs=not-pressed,
//   o_mode=0, o_short_pulse=0, o_long_pulse=0, o_pressed=0.
//  Input path: i_btn -> polarity normalise -> 2-FF synchroniser -> btn_s (1 = pressed).
//  Counters:
//   - db_cnt: width $clog2(DEBOUNCE_CYC).
//   - hold_cnt: width $clog2(LONG_CYC); saturates, never wraps.
//  FSM:
//   IDLE     btn_s=1 -> PRESS_DB, db_cnt=0.
//   PRESS_DB btn_s=0 -> IDLE (glitch, no output).
//            btn_s=1: db_cnt++; at db_cnt==DEBOUNCE_CYC-1 -> HELD, hold_cnt=0.
//   HELD     btn_s=0 -> REL_DB, short_flag=1, db_cnt=0.
//            else hold_cnt++; at hold_cnt==LONG_CYC-1 -> LONG, o_long_pulse=1 that edge.
//   LONG     btn_s=0 -> REL_DB, short_flag=0, db_cnt=0; otherwise stay (no repeat pulse).
//   REL_DB   btn_s=1 -> db_cnt=0, stay (release bounce); press class is not re-evaluated.
//            btn_s=0: db_cnt++; at db_cnt==DEBOUNCE_CYC-1 -> IDLE;
//            if short_flag: o_short_pulse=1 and o_mode toggles on the same edge.
//  Pulses are registered and high for exactly one cycle. The two pulses never coincide.
//  Latency, press edge to HELD: 2 sync cycles + DEBOUNCE_CYC cycles.
//  Latency, release to short pulse: 2 + DEBOUNCE_CYC cycles.
//  Long press never changes o_mode.
//  Press shorter than DEBOUNCE_CYC samples: ignored entirely.
//  Reset mid-press: everything returns to reset values immediately.
//   - A press still held after reset release is a new press from IDLE.
//   - That press is debounced again before any action.
//  o_mode holds its value indefinitely between short presses; no timeout.
// TESTING (bench params: DEBOUNCE_CYC=4, LONG_CYC=20, BTN_ACT_HIGH=1)
//  1 Reset: assert i_rst_n=0 mid-cycle -> all outputs 0 immediately (asynchronous, before next edge).
//  2 Glitch: i_btn=1 for 3 cycles then 0 -> no pulses, o_mode=0, o_pressed never 1.
//  3 Short press: i_btn=1 for 10 cycles, then 0 ->
//    o_pressed rises 6 cycles after press; one o_short_pulse 6 cycles after release;
//    o_mode 0->1. Repeat -> o_mode 1->0.
//  4 Long press: i_btn=1 for 40 cycles ->
//    one o_long_pulse ~26 cycles after press; no short pulse on release; o_mode unchanged.
//  5 Bounce: press with 1-cycle 0 glitches every 2 cycles for 8 cycles, then solid 1 ->
//    exactly one accepted press.
//    Release with bounces -> exactly one short pulse.
//  6 Reset mid-press: i_rst_n=0 while in HELD, i_btn stays 1, release reset ->
//    o_pressed=0 in reset; re-debounce;
//    after release: exactly one short pulse, o_mode=1.

Source files
------------

// File: rtl/mode_btn_ctrl.sv
// -----------------------------------------------------------------------------
// mode_btn_ctrl
//
// Conditions the raw mode push-button for the watch top level.
//   * Normalises the button polarity, then brings it into the sysclk domain
//     through a 2-FF synchroniser.
//   * Debounces press and release edges (DEBOUNCE_CYC consecutive samples).
//   * Classifies each accepted press as short or long (LONG_CYC held cycles).
//   * Short press: toggles o_mode (0 = clock view, 1 = up-counter view) and
//     emits o_short_pulse once the release has been debounced.
//   * Long press: emits o_long_pulse once when the hold threshold is reached;
//     o_mode is left untouched.
//
// Ports
//   sysclk         in   system clock, all logic on the rising edge
//   i_rst_n        in   asynchronous active-low reset
//   i_btn          in   raw asynchronous button pin
//   o_mode         out  display mode select, toggles on each short press
//   o_short_pulse  out  one-cycle pulse, short press completed
//   o_long_pulse   out  one-cycle pulse, long-press threshold reached
//   o_pressed      out  debounced button level (1 while HELD or LONG)
//
// Handshake note: there is no valid/ready traffic in this block. The two
// pulse outputs are registered strobes, high for exactly one sysclk cycle,
// and they are never high together (each is raised from a different state).
// -----------------------------------------------------------------------------
module mode_btn_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter bit BTN_ACT_HIGH = 1'b1
) (
  input  logic sysclk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_mode,
  output logic o_short_pulse,
  output logic o_long_pulse,
  output logic o_pressed
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(LONG_CYC);

  // Terminal counts. A counter reaching these values on its increment marks
  // the final sample of the window.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_HELD     = 3'd2,
    S_LONG     = 3'd3,
    S_REL_DB   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input path: polarity normalise -> 2-FF synchroniser
  // ---------------------------------------------------------------------------
  logic w_btn_norm;
  logic r_sync1;
  logic r_sync2;
  logic w_btn_s;

  // After normalisation 1 always means "pressed", so the synchroniser resets
  // to the not-pressed level regardless of pin polarity.
  assign w_btn_norm = BTN_ACT_HIGH ? i_btn : ~i_btn;

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_btn_norm;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [DB_W-1:0]    r_db_cnt;
  logic [DB_W-1:0]    w_db_cnt_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_cnt_nxt;
  logic               r_short_flag;
  logic               w_short_flag_nxt;
  logic               r_mode;
  logic               w_mode_nxt;
  logic               r_short_pulse;
  logic               w_short_pulse_nxt;
  logic               r_long_pulse;
  logic               w_long_pulse_nxt;

  logic [DB_W-1:0]    w_db_inc;
  logic [HOLD_W-1:0]  w_hold_inc;

  assign w_db_inc = r_db_cnt + DB_W'(1);

  // The hold counter saturates at its terminal count so a stuck button can
  // never wrap it back into a second long-press detection.
  assign w_hold_inc = (r_hold_cnt == HOLD_LAST) ? r_hold_cnt
                                                : r_hold_cnt + HOLD_W'(1);

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_db_cnt      <= '0;
      r_hold_cnt    <= '0;
      r_short_flag  <= 1'b0;
      r_mode        <= 1'b0;
      r_short_pulse <= 1'b0;
      r_long_pulse  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_db_cnt      <= w_db_cnt_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_short_flag  <= w_short_flag_nxt;
      r_mode        <= w_mode_nxt;
      r_short_pulse <= w_short_pulse_nxt;
      r_long_pulse  <= w_long_pulse_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_db_cnt_nxt      = r_db_cnt;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_short_flag_nxt  = r_short_flag;
    w_mode_nxt        = r_mode;
    w_short_pulse_nxt = 1'b0;
    w_long_pulse_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // The sample that leaves IDLE is the first of the debounce window.
        if (w_btn_s) begin
          w_state_nxt  = S_PRESS_DB;
          w_db_cnt_nxt = '0;
        end
      end

      S_PRESS_DB: begin
        if (!w_btn_s) begin
          // Too short to be a press: drop it silently.
          w_state_nxt  = S_IDLE;
          w_db_cnt_nxt = '0;
        end else if (w_db_inc == DB_LAST) begin
          w_state_nxt    = S_HELD;
          w_db_cnt_nxt   = '0;
          w_hold_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = w_db_inc;
        end
      end

      S_HELD: begin
        if (!w_btn_s) begin
          // Released before the long threshold: remember it was short.
          w_state_nxt      = S_REL_DB;
          w_short_flag_nxt = 1'b1;
          w_db_cnt_nxt     = '0;
        end else begin
          w_hold_cnt_nxt = w_hold_inc;
          if (w_hold_inc == HOLD_LAST) begin
            w_state_nxt      = S_LONG;
            w_long_pulse_nxt = 1'b1;
          end
        end
      end

      S_LONG: begin
        // Holding further gives no repeat pulse.
        if (!w_btn_s) begin
          w_state_nxt      = S_REL_DB;
          w_short_flag_nxt = 1'b0;
          w_db_cnt_nxt     = '0;
        end
      end

      S_REL_DB: begin
        if (w_btn_s) begin
          // Release bounce restarts the window; the press class was already
          // decided on the way in and is not revisited.
          w_db_cnt_nxt = '0;
        end else if (w_db_inc == DB_LAST) begin
          w_state_nxt  = S_IDLE;
          w_db_cnt_nxt = '0;
          if (r_short_flag) begin
            w_short_pulse_nxt = 1'b1;
            w_mode_nxt        = ~r_mode;
          end
          w_short_flag_nxt = 1'b0;
        end else begin
          w_db_cnt_nxt = w_db_inc;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_db_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_mode        = r_mode;
  assign o_short_pulse = r_short_pulse;
  assign o_long_pulse  = r_long_pulse;
  assign o_pressed     = (r_state == S_HELD) || (r_state == S_LONG);

endmodule

// File: tb/tb_mode_btn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mode_btn_ctrl
//
// Directed scenarios (reset, glitch, short, long, bounce, reset mid-press)
// followed by randomized presses. A behavioural model tracks the button as
// run lengths of pressed/released samples and predicts every output each
// cycle; directed latency and event-count checks use constants derived from
// the debounce/long-press rules.
// -----------------------------------------------------------------------------
module tb_mode_btn_ctrl;

  localparam int D = 4;
  localparam int L = 20;
  // Press edge to o_pressed: 2 synchroniser cycles + D debounce samples.
  localparam int PRESS_LAT = 2 + D;
  // Press edge to long pulse: debounce latency + L-1 further held cycles.
  localparam int LONG_LAT  = 2 + D + (L - 1);
  // Release edge to short pulse.
  localparam int REL_LAT   = 2 + D;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic sysclk = 1'b0;
  logic i_rst_n;
  logic i_btn;
  logic o_mode;
  logic o_short_pulse;
  logic o_long_pulse;
  logic o_pressed;

  always #5 sysclk = ~sysclk;

  mode_btn_ctrl #(
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L),
    .BTN_ACT_HIGH (1'b1)
  ) dut (
    .sysclk        (sysclk),
    .i_rst_n       (i_rst_n),
    .i_btn         (i_btn),
    .o_mode        (o_mode),
    .o_short_pulse (o_short_pulse),
    .o_long_pulse  (o_long_pulse),
    .o_pressed     (o_pressed)
  );

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic dly_q[$];   // raw button delayed by the two synchroniser stages
  bit   m_down;     // a press has been accepted and not yet fully released
  bit   m_rel;      // first released sample seen since acceptance
  bit   m_long;     // press already classified as long
  int   m_run;      // consecutive samples counted toward the current window
  int   m_held;     // cycles held after acceptance
  bit   m_mode;
  bit   m_short;
  bit   m_longp;

  task automatic model_reset();
    dly_q   = {1'b0, 1'b0};
    m_down  = 0;
    m_rel   = 0;
    m_long  = 0;
    m_run   = 0;
    m_held  = 0;
    m_mode  = 0;
    m_short = 0;
    m_longp = 0;
  endtask

  task automatic model_edge(input logic b);
    logic s;
    dly_q.push_back(b);
    s = dly_q.pop_front();
    m_short = 0;
    m_longp = 0;
    if (!m_down) begin
      m_run = s ? m_run + 1 : 0;
      if (m_run == D) begin
        m_down = 1;
        m_rel  = 0;
        m_long = 0;
        m_held = 0;
        m_run  = 0;
      end
    end else if (!m_rel) begin
      if (!s) begin
        m_rel = 1;
        m_run = 1;
      end else if (!m_long) begin
        m_held++;
        if (m_held == L - 1) begin
          m_long  = 1;
          m_longp = 1;
        end
      end
    end else begin
      // A bounce sample restarts the release window and occupies its first slot.
      if (s) begin
        m_run = 1;
      end else begin
        m_run++;
        if (m_run == D) begin
          m_down = 0;
          m_rel  = 0;
          m_run  = 0;
          if (!m_long) begin
            m_short = 1;
            m_mode  = ~m_mode;
          end
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checkers and phase observation
  // ---------------------------------------------------------------------------
  int idx, n_short, n_long, n_press_rise;
  int first_press_idx, first_short_idx, first_long_idx;
  logic pressed_prev;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic phase_start();
    idx             = 0;
    n_short         = 0;
    n_long          = 0;
    n_press_rise    = 0;
    first_press_idx = -1;
    first_short_idx = -1;
    first_long_idx  = -1;
    pressed_prev    = o_pressed;
  endtask

  task automatic observe();
    if (o_short_pulse === 1'b1) begin
      n_short++;
      if (first_short_idx < 0) first_short_idx = idx;
    end
    if (o_long_pulse === 1'b1) begin
      n_long++;
      if (first_long_idx < 0) first_long_idx = idx;
    end
    if (o_pressed === 1'b1 && pressed_prev !== 1'b1) begin
      n_press_rise++;
      if (first_press_idx < 0) first_press_idx = idx;
    end
    pressed_prev = o_pressed;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic b);
    i_btn = b;
    @(posedge sysclk);
    model_edge(b);
    @(negedge sysclk);
    idx++;
    chk("mode", o_mode, m_mode);
    chk("pressed", o_pressed, m_down && !m_rel);
    chk("short_pulse", o_short_pulse, m_short);
    chk("long_pulse", o_long_pulse, m_longp);
    chk("pulse_excl", o_short_pulse & o_long_pulse, 1'b0);
    observe();
  endtask

  // Called at a falling edge: asserts reset mid-cycle, checks the outputs
  // clear before the next rising edge, holds reset, releases at a falling edge.
  task automatic mid_reset();
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_async_mode", o_mode, 1'b0);
    chk("rst_async_pressed", o_pressed, 1'b0);
    chk("rst_async_short", o_short_pulse, 1'b0);
    chk("rst_async_long", o_long_pulse, 1'b0);
    model_reset();
    repeat (3) begin
      @(posedge sysclk);
      @(negedge sysclk);
      chk("rst_hold_pressed", o_pressed, 1'b0);
      chk("rst_hold_mode", o_mode, 1'b0);
    end
    i_rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    i_rst_n = 1'b0;
    i_btn   = 1'b0;
    model_reset();
    @(negedge sysclk);
    chk("reset_mode", o_mode, 1'b0);
    chk("reset_pressed", o_pressed, 1'b0);
    chk("reset_short", o_short_pulse, 1'b0);
    chk("reset_long", o_long_pulse, 1'b0);
    i_rst_n = 1'b1;
    repeat (3) cyc(1'b0);

    // Glitch: three pressed cycles are one short of a debounce window.
    phase_start();
    repeat (3) cyc(1'b1);
    repeat (10) cyc(1'b0);
    chk_int("glitch_short_cnt", n_short, 0);
    chk_int("glitch_long_cnt", n_long, 0);
    chk_int("glitch_pressed_rise", n_press_rise, 0);
    chk("glitch_mode", o_mode, 1'b0);

    // Two short presses: mode 0 -> 1 -> 0.
    for (int k = 0; k < 2; k++) begin
      phase_start();
      repeat (10) cyc(1'b1);
      chk_int("short_press_lat", first_press_idx, PRESS_LAT);
      phase_start();
      repeat (10) cyc(1'b0);
      chk_int("short_rel_lat", first_short_idx, REL_LAT);
      chk_int("short_cnt", n_short, 1);
      chk("short_mode", o_mode, (k == 0) ? 1'b1 : 1'b0);
    end

    // Long press: one long pulse, no short pulse, mode unchanged.
    phase_start();
    repeat (40) cyc(1'b1);
    chk_int("long_lat", first_long_idx, LONG_LAT);
    chk_int("long_cnt", n_long, 1);
    phase_start();
    repeat (10) cyc(1'b0);
    chk_int("long_rel_short_cnt", n_short, 0);
    chk_int("long_rel_long_cnt", n_long, 0);
    chk("long_mode", o_mode, 1'b0);

    // Bouncy press then bouncy release: exactly one press, one short pulse.
    phase_start();
    repeat (4) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    repeat (15) cyc(1'b1);
    chk_int("bounce_press_cnt", n_press_rise, 1);
    phase_start();
    repeat (3) begin
      cyc(1'b0);
      cyc(1'b1);
    end
    repeat (10) cyc(1'b0);
    chk_int("bounce_short_cnt", n_short, 1);
    chk("bounce_mode", o_mode, 1'b1);

    // Reset while HELD with the button kept down: re-debounced as a new press.
    phase_start();
    repeat (8) cyc(1'b1);
    chk("t6_held_before_reset", o_pressed, 1'b1);
    mid_reset();
    phase_start();
    repeat (10) cyc(1'b1);
    chk_int("t6_repress_lat", first_press_idx, PRESS_LAT);
    phase_start();
    repeat (10) cyc(1'b0);
    chk_int("t6_short_cnt", n_short, 1);
    chk("t6_mode", o_mode, 1'b1);

    // Randomized presses with leading bounce on both edges.
    for (int n = 0; n < 40; n++) begin
      int plen;
      int rlen;
      plen = $urandom_range(1, 45);
      rlen = $urandom_range(1, 30);
      for (int i = 0; i < plen; i++)
        cyc((i < 6 && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1);
      for (int i = 0; i < rlen; i++)
        cyc((i < 6 && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      if (n == 20) begin
        cyc(1'b1);
        mid_reset();
      end
    end
    repeat (12) cyc(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
